foreperiod_gen: RTL and testbench



---
 rtl/foreperiod_gen.sv | 104 ++++++++++
 tb/tb_foreperiod_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/foreperiod_gen.sv
// rtl/foreperiod_gen.sv - random foreperiod generator for the reaction timer
// Optional FOREPERIOD_FIXED_EN: foreperiod is always MIN_MS (LFSR keeps running).
module foreperiod_gen #(
    parameter int CLK_HZ     = 50000000,
    parameter int MIN_MS     = 1000,
    parameter int RANGE_BITS = 11
) (
    input  logic        clk_50M,
    input  logic        clear,
    input  logic        arm,
    input  logic        abort,
    output logic        go_pulse,
    output logic        early_pulse,
    output logic        waiting,
    output logic [11:0] delay_ms,
    output logic [11:0] remaining_ms
);

    localparam int CYC_PER_MS = CLK_HZ / 1000;
    localparam int PS_W       = (CYC_PER_MS > 2) ? $clog2(CYC_PER_MS) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CYC_PER_MS - 1);
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    if ((MIN_MS + (1 << RANGE_BITS) - 1) > 4095) begin : g_width_check
        $error("foreperiod_gen: MIN_MS + 2^RANGE_BITS - 1 exceeds 12 bits");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        FIRE = 2'd2
    } state_t;

    state_t          state;
    logic [15:0]     lfsr;
    logic [PS_W-1:0] prescaler;
    logic            lfsr_fb;
    logic [11:0]     next_delay;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

`ifdef FOREPERIOD_FIXED_EN
    assign next_delay = 12'(MIN_MS);
`else
    assign next_delay = 12'(MIN_MS) + 12'(lfsr[RANGE_BITS-1:0]);
`endif

    always_ff @(posedge clk_50M) begin
        if (clear) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            prescaler    <= '0;
            go_pulse     <= 1'b0;
            early_pulse  <= 1'b0;
            waiting      <= 1'b0;
            delay_ms     <= 12'd0;
            remaining_ms <= 12'd0;
        end else begin
            lfsr        <= {lfsr[14:0], lfsr_fb};
            go_pulse    <= 1'b0;
            early_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        delay_ms     <= next_delay;
                        remaining_ms <= next_delay;
                        prescaler    <= '0;
                        waiting      <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    // abort beats a coincident final tick, so no go can follow it
                    if (abort) begin
                        early_pulse  <= 1'b1;
                        remaining_ms <= 12'd0;
                        prescaler    <= '0;
                        waiting      <= 1'b0;
                        state        <= IDLE;
                    end else if (prescaler == PS_MAX) begin
                        prescaler <= '0;
                        if (remaining_ms <= 12'd1) begin
                            remaining_ms <= 12'd0;
                            waiting      <= 1'b0;
                            go_pulse     <= 1'b1;
                            state        <= FIRE;
                        end else begin
                            remaining_ms <= remaining_ms - 12'd1;
                        end
                    end else begin
                        prescaler <= prescaler + 1'b1;
                    end
                end
                FIRE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_foreperiod_gen.sv
// tb/tb_foreperiod_gen.sv - randomized bench for foreperiod_gen against an elapsed-time model
module tb_foreperiod_gen;

    localparam int CLK_HZ = 10000;
    localparam int MIN_MS = 5;
    localparam int RANGE_BITS = 3;
    localparam int N = CLK_HZ / 1000;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic        go_pulse, early_pulse, waiting;
    logic [11:0] delay_ms, remaining_ms;

    int n_cmp = 0;
    int n_bad = 0;

    // model: mode 0=idle 1=waiting 2=fire cycle; m_t = edges since the accepted arm
    int          m_mode = 0;
    int          m_t = 0;
    int          m_d = 0;
    int          m_delay = 0;
    int          m_early = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    foreperiod_gen #(.CLK_HZ(CLK_HZ), .MIN_MS(MIN_MS), .RANGE_BITS(RANGE_BITS)) dut (
        .clk_50M(clk), .clear(clear), .arm(arm), .abort(abort),
        .go_pulse(go_pulse), .early_pulse(early_pulse), .waiting(waiting),
        .delay_ms(delay_ms), .remaining_ms(remaining_ms)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic c, input logic a, input logic ab);
        logic [15:0] cur;
        if (c) begin
            m_mode = 0; m_delay = 0; m_early = 0; m_lfsr = 16'hACE1;
            return;
        end
        cur = m_lfsr;
        m_lfsr = lfsr_next(cur);
        m_early = 0;
        case (m_mode)
            0: if (a) begin
`ifdef FOREPERIOD_FIXED_EN
                m_d = MIN_MS;
`else
                m_d = MIN_MS + int'(cur) % (1 << RANGE_BITS);
`endif
                m_delay = m_d; m_t = 0; m_mode = 1;
            end
            1: begin
                m_t++;
                if (ab) begin
                    m_early = 1; m_mode = 0;
                end else if (m_t == m_d * N) begin
                    m_mode = 2;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    function automatic int model_rem();
        return (m_mode == 1) ? (m_d - m_t / N) : 0;
    endfunction

    // one clock: drive after negedge, advance model, sample 1 time unit after posedge
    task automatic step(input logic c, input logic a, input logic ab);
        @(negedge clk);
        clear = c; arm = a; abort = ab;
        model_update(c, a, ab);
        @(posedge clk);
        #1;
        check("go_pulse", int'(go_pulse), (m_mode == 2) ? 1 : 0);
        check("early_pulse", int'(early_pulse), m_early);
        check("waiting", int'(waiting), (m_mode == 1) ? 1 : 0);
        check("delay_ms", int'(delay_ms), m_delay);
        check("remaining_ms", int'(remaining_ms), model_rem());
    endtask

    task automatic run_to_idle(input int budget);
        int k;
        k = 0;
        while (m_mode != 0 && k < budget) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        check("idle_within_budget", (m_mode == 0) ? 1 : 0, 1);
    endtask

    logic [15:0] seen;
    int          distinct;

    initial begin
        int n;
        int got_go;
        seen = '0;

        // reset value and first foreperiod from the seed
        repeat (3) step(1'b1, 1'b0, 1'b0);
        check("reset_delay", int'(delay_ms), 0);
        check("reset_waiting", int'(waiting), 0);
        step(1'b0, 1'b1, 1'b0);
`ifdef FOREPERIOD_FIXED_EN
        check("first_delay_lit", int'(delay_ms), 5);
`else
        check("first_delay_lit", int'(delay_ms), 6);
`endif
        check("first_rem_lit", int'(remaining_ms), int'(delay_ms));
        n = 1;
        got_go = 0;
        while (!got_go && n < 200) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
            got_go = int'(go_pulse);
        end
`ifdef FOREPERIOD_FIXED_EN
        check("go_cycle_lit", n, 51);
`else
        check("go_cycle_lit", n, 61);
`endif
        step(1'b0, 1'b0, 1'b0);
        check("go_width_lit", int'(go_pulse), 0);

        // abort mid-wait at cycle 25
        step(1'b0, 1'b1, 1'b0);
        repeat (24) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("abort_early_lit", int'(early_pulse), 1);
        check("abort_rem_lit", int'(remaining_ms), 0);
        repeat (130) step(1'b0, 1'b0, 1'b0);

        // abort on the final ms tick
        step(1'b0, 1'b1, 1'b0);
        while (m_mode == 1 && m_t < m_d * N - 1) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("race_early_lit", int'(early_pulse), 1);
        check("race_go_lit", int'(go_pulse), 0);
        repeat (5) step(1'b0, 1'b0, 1'b0);

        // ignored events: abort in idle, arm in wait, arm+abort in idle
        repeat (3) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("arm_abort_idle_waiting", int'(waiting), 1);
        repeat (7) step(1'b0, 1'b1, 1'b0);
        run_to_idle(200);

        // clear with 3 ms remaining
        step(1'b0, 1'b1, 1'b0);
        while (m_mode == 1 && model_rem() != 3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("clear_mid_rem_lit", int'(remaining_ms), 0);
        check("clear_mid_wait_lit", int'(waiting), 0);
        repeat (60) step(1'b0, 1'b0, 1'b0);

        // randomized arm/fire loop, back-to-back arms after FIRE
        for (int trial = 0; trial < 50; trial++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            step(1'b0, 1'b1, 1'b0);
            seen[delay_ms[3:0]] = 1'b1;
            for (int k = 0; k < 200 && m_mode != 0; k++) begin
                step(1'b0, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 299) == 0));
            end
            check("trial_ends_idle", (m_mode == 0) ? 1 : 0, 1);
        end
        distinct = 0;
        for (int v = 0; v < 16; v++) distinct += int'(seen[v]);
`ifdef FOREPERIOD_FIXED_EN
        check("fixed_distinct", distinct, 1);
`else
        check("random_spread", (distinct >= 4) ? 1 : 0, 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
